turn_queue: RTL and testbench

//  Front end of snake steering; replaces the combinational KEY decoder that feeds datapath.direction.

---
 rtl/turn_queue.sv | 82 ++++++++
 tb/tb_turn_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/turn_queue.sv
// turn_queue: debounced buttons and keyboard edges become turn requests, filtered and queued, one applied per tick
module turn_queue #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       kb_up,
  input  logic       kb_left,
  input  logic       kb_down,
  input  logic       kb_right,
  input  logic       enable,
  input  logic       tick,
  output logic [4:0] direction,
  output logic [2:0] pending,
  output logic       overflow
);
  localparam logic [CNT_W-1:0] DLIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] DP = 3'(DEPTH);
  localparam logic [2:0] DL = 3'(DEPTH - 1);
  logic [3:0] s1, s2, db, db_d, kbd, kbv, btn, req;
  logic [CNT_W-1:0] cnt [4];
  logic [4:0] q [8];
  logic [2:0] rp, wp, lp;
  logic [4:0] r, t, t_opp;
  logic ok, pop, push;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      db <= '1;
      db_d <= '1;
      kbd <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      db_d <= db;
      kbd <= kbv;
      for (int i = 0; i < 4; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DLIM) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  // request bits ordered up, left, down, right; lowest index wins
  always_comb begin
    kbv = {kb_right, kb_down, kb_left, kb_up};
    btn = db_d & ~db;
    req = (kbv & ~kbd) | {btn[0], btn[1], btn[3], btn[2]};
    r = req[0] ? 5'b00010 : req[1] ? 5'b00100 : req[2] ? 5'b01000 : req[3] ? 5'b10000 : 5'b00000;
    lp = (wp == 3'd0) ? DL : wp - 3'd1;
    t = (pending != 3'd0) ? q[lp] : direction;
    t_opp = {t[2], t[1], t[4], t[3], 1'b0};
    ok = enable && r != 5'd0 && !(t != 5'd0 && (r == t || r == t_opp));
    pop = tick && enable && pending != 3'd0;
    push = ok && (pending != DP || pop);
  end
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      rp <= '0;
      wp <= '0;
      pending <= '0;
      direction <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        direction <= q[rp];
        rp <= (rp == DL) ? 3'd0 : rp + 3'd1;
      end
      if (push) wp <= (wp == DL) ? 3'd0 : wp + 3'd1;
      pending <= pending + {2'b0, push} - {2'b0, pop};
      if (ok && !push) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) q[wp] <= r;
endmodule

// File: tb/tb_turn_queue.sv
// tb_turn_queue: randomized and directed stimulus checked every cycle against a queue-based model
module tb_turn_queue;
  localparam int D = 8;
  localparam int DEPTH = 2;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, tick = 1'b0;
  logic [3:0] key_n = 4'hf;
  logic [3:0] kb = 4'h0;
  logic [4:0] direction;
  logic [2:0] pending;
  logic overflow;
  int checks = 0, errors = 0, cyc = 0;

  turn_queue #(.DEBOUNCE_CYCLES(D), .CNT_W(20), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .kb_up(kb[0]), .kb_left(kb[1]), .kb_down(kb[2]), .kb_right(kb[3]),
    .enable(enable), .tick(tick),
    .direction(direction), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // model: headings as one-hot values, queue of accepted turns, per-button run length of disagreement
  logic [4:0] mq[$];
  logic [4:0] mdir, mr, mt;
  logic movf, mok;
  logic [3:0] k1, k2, acc, prs, kbp, mrq;
  int mm[4];

  function automatic logic [4:0] opposite(input logic [4:0] h);
    return h == 5'd2 ? 5'd8 : h == 5'd8 ? 5'd2 : h == 5'd4 ? 5'd16 : h == 5'd16 ? 5'd4 : 5'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mdir = 0; movf = 0; k1 = '1; k2 = '1; acc = '1; prs = 0; kbp = 0;
      for (int i = 0; i < 4; i++) mm[i] = 0;
    end else begin
      mrq = (kb & ~kbp) | {prs[0], prs[1], prs[3], prs[2]};
      kbp = kb;
      if (!enable) begin
        mq.delete(); mdir = 0; movf = 0;
      end else begin
        mr = mrq[0] ? 5'd2 : mrq[1] ? 5'd4 : mrq[2] ? 5'd8 : mrq[3] ? 5'd16 : 5'd0;
        mt = (mq.size() > 0) ? mq[$] : mdir;
        mok = mr != 0 && !(mt != 0 && (mr == mt || mr == opposite(mt)));
        if (tick && mq.size() > 0) mdir = mq.pop_front();
        if (mok) begin
          if (mq.size() < DEPTH) mq.push_back(mr);
          else movf = 1;
        end
      end
      prs = 0;
      for (int i = 0; i < 4; i++) begin
        if (k2[i] == acc[i]) mm[i] = 0;
        else begin
          mm[i]++;
          if (mm[i] == D) begin
            acc[i] = k2[i];
            mm[i] = 0;
            if (!acc[i]) prs[i] = 1;
          end
        end
      end
      k2 = k1;
      k1 = key_n;
    end
  end

  task automatic compare();
    checks++;
    if (direction !== mdir || pending !== 3'(mq.size()) || overflow !== movf) begin
      errors++;
      $display("FAIL model cyc=%0d dut dir=%b pend=%0d ovf=%b want dir=%b pend=%0d ovf=%b",
               cyc, direction, pending, overflow, mdir, mq.size(), movf);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1; kb = 0; key_n = 4'hf; enable = 1; tick = 0;
    step(); step();
    reset = 0;
    step();
  endtask

  task automatic pulse(input int d);
    kb[d] = 1'b1;
    step();
    kb = 0;
    step();
  endtask

  task automatic do_tick();
    tick = 1;
    step();
    tick = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_dir", direction, 0);
    chk("reset_pend", pending, 0);
    chk("reset_ovf", overflow, 0);
    // 1: debounced up button, 11-cycle latency
    key_n = 4'b1011;
    repeat (10) step();
    chk("t1_pend_early", pending, 0);
    step();
    chk("t1_pend", pending, 1);
    repeat (9) step();
    key_n = 4'hf;
    repeat (12) step();
    do_tick();
    chk("t1_dir", direction, 5'b00010);
    chk("t1_pend_after", pending, 0);
    // 2: bouncing button never accepted
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key_n[2] = ~key_n[2];
      repeat (3) step();
    end
    key_n = 4'hf;
    repeat (12) step();
    chk("t2_pend", pending, 0);
    chk("t2_dir", direction, 0);
    // 3: duplicate/opposite filtering
    do_reset();
    pulse(0);
    do_tick();
    chk("t3_dir", direction, 5'b00010);
    pulse(2);
    chk("t3_down_rej", pending, 0);
    pulse(1);
    chk("t3_left", pending, 1);
    pulse(3);
    chk("t3_right_rej", pending, 1);
    // 4: overflow then two ticks
    do_reset();
    pulse(3); pulse(0); pulse(1);
    chk("t4_pend", pending, 2);
    chk("t4_ovf", overflow, 1);
    do_tick();
    chk("t4_dir1", direction, 5'b10000);
    do_tick();
    chk("t4_dir2", direction, 5'b00010);
    // 5: push and pop in the same cycle when full
    do_reset();
    pulse(3); pulse(0);
    tick = 1; kb[1] = 1'b1;
    step();
    tick = 0; kb = 0;
    step();
    chk("t5_dir", direction, 5'b10000);
    chk("t5_pend", pending, 2);
    chk("t5_ovf", overflow, 0);
    do_tick();
    chk("t5_head", direction, 5'b00010);
    do_tick();
    chk("t5_tail", direction, 5'b00100);
    // 6: priority and flush
    do_reset();
    kb = 4'b1001;
    step();
    chk("t6_pend", pending, 1);
    kb = 0;
    step();
    enable = 0;
    step();
    chk("t6_flush_pend", pending, 0);
    chk("t6_flush_dir", direction, 0);
    enable = 1;
    step();
    // random phase
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) key_n = 4'($urandom);
      kb = kb ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      tick = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 60) != 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
